// File: rtl/reg_ref_file_pkg.sv
// Shared widths and types for the register file with rename status.
// Imported by the register file top and its read-port sub-module.
package reg_ref_file_pkg;

   localparam int DATA_WIDTH             = 32;
   localparam int REG_ADDR_WIDTH         = 5;
   localparam int NUM_REGS               = 32;
   localparam int ROB_ADDR_WIDTH_DEFAULT = 4;

   typedef logic [DATA_WIDTH-1:0]     data_t;
   typedef logic [REG_ADDR_WIDTH-1:0] regAddr_t;

endpackage

// File: rtl/reg_ref_read_port.sv
// One combinational read port: returns a committed value or the pending ROB tag,
// with a same-cycle bypass when the matching ROB slot is committing this register.
module reg_ref_read_port
   import reg_ref_file_pkg::*;
#(
   parameter int ROB_ADDR_WIDTH = ROB_ADDR_WIDTH_DEFAULT
) (
   input  logic                      en_i,
   input  regAddr_t                  addr_i,
   input  data_t                     value_i [NUM_REGS],
   input  logic [NUM_REGS-1:0]       isRef_i,
   input  logic [ROB_ADDR_WIDTH-1:0] tag_i [NUM_REGS],
   input  logic                      commitEn_i,
   input  regAddr_t                  commitAddr_i,
   input  logic [ROB_ADDR_WIDTH-1:0] commitRobId_i,
   input  data_t                     commitData_i,
   output logic                      isRef_o,
   output data_t                     data_o
);

   logic bypassHit;

   // A stale commit (tag mismatch) must not hide the newer rename, so the tag is compared.
   assign bypassHit = commitEn_i && (commitAddr_i == addr_i) && isRef_i[addr_i]
                      && (tag_i[addr_i] == commitRobId_i);

   always_comb begin
      isRef_o = 1'b0;
      data_o  = '0;
      if (en_i) begin
         if (bypassHit) begin
            data_o = commitData_i;
         end else if (isRef_i[addr_i]) begin
            isRef_o = 1'b1;
            data_o  = data_t'(tag_i[addr_i]);
         end else begin
            data_o = value_i[addr_i];
         end
      end
   end

endmodule

// File: rtl/reg_ref_file.sv
// Architectural register file with per-register rename status, written by decode-time
// rename and ROB commit, read through two combinational ports.
module reg_ref_file
   import reg_ref_file_pkg::*;
#(
   parameter int ROB_ADDR_WIDTH = ROB_ADDR_WIDTH_DEFAULT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      read_en_1,
   input  logic [4:0]                read_addr_1,
   output logic                      read_is_ref_1,
   output logic [31:0]               read_data_1,
   input  logic                      read_en_2,
   input  logic [4:0]                read_addr_2,
   output logic                      read_is_ref_2,
   output logic [31:0]               read_data_2,
   input  logic                      rename_en,
   input  logic [4:0]                rename_addr,
   input  logic [ROB_ADDR_WIDTH-1:0] rename_rob_id,
   input  logic                      commit_en,
   input  logic [4:0]                commit_addr,
   input  logic [ROB_ADDR_WIDTH-1:0] commit_rob_id,
   input  logic [31:0]               commit_data
);

   data_t                     value_q [NUM_REGS];
   data_t                     value_d [NUM_REGS];
   logic [NUM_REGS-1:0]       isRef_q;
   logic [NUM_REGS-1:0]       isRef_d;
   logic [ROB_ADDR_WIDTH-1:0] tag_q   [NUM_REGS];
   logic [ROB_ADDR_WIDTH-1:0] tag_d   [NUM_REGS];

   // Commit first, then rename, so a same-register rename in the same cycle wins.
   // Register 0 is never written, so it stays zero and never becomes a reference.
   always_comb begin
      value_d = value_q;
      isRef_d = isRef_q;
      tag_d   = tag_q;
      if (commit_en && (commit_addr != '0)) begin
         value_d[commit_addr] = commit_data;
         if (isRef_q[commit_addr] && (tag_q[commit_addr] == commit_rob_id)) begin
            isRef_d[commit_addr] = 1'b0;
         end
      end
      if (flush) begin
         isRef_d = '0;
      end else if (rename_en && (rename_addr != '0)) begin
         isRef_d[rename_addr] = 1'b1;
         tag_d[rename_addr]   = rename_rob_id;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            value_q[i] <= '0;
            tag_q[i]   <= '0;
         end
         isRef_q <= '0;
      end else begin
         value_q <= value_d;
         isRef_q <= isRef_d;
         tag_q   <= tag_d;
      end
   end

   reg_ref_read_port #(
      .ROB_ADDR_WIDTH (ROB_ADDR_WIDTH)
   ) readPort1 (
      .en_i          (read_en_1),
      .addr_i        (read_addr_1),
      .value_i       (value_q),
      .isRef_i       (isRef_q),
      .tag_i         (tag_q),
      .commitEn_i    (commit_en),
      .commitAddr_i  (commit_addr),
      .commitRobId_i (commit_rob_id),
      .commitData_i  (commit_data),
      .isRef_o       (read_is_ref_1),
      .data_o        (read_data_1)
   );

   reg_ref_read_port #(
      .ROB_ADDR_WIDTH (ROB_ADDR_WIDTH)
   ) readPort2 (
      .en_i          (read_en_2),
      .addr_i        (read_addr_2),
      .value_i       (value_q),
      .isRef_i       (isRef_q),
      .tag_i         (tag_q),
      .commitEn_i    (commit_en),
      .commitAddr_i  (commit_addr),
      .commitRobId_i (commit_rob_id),
      .commitData_i  (commit_data),
      .isRef_o       (read_is_ref_2),
      .data_o        (read_data_2)
   );

endmodule
